rate_encoder: RTL
=================

# rate_encoder

Converts a vector of per-channel intensity values into spike trains over a fixed window of network timesteps, one spike bit per channel per timestep. Sits at the input edge of the SNN and drives the `spike_in` vector of the first layer of `if_neuron` instances. A valid/ready load handshake accepts a new value vector; the `step` strobe advances time; `window_done` marks the end of each window.

## Interface

Parameters:
- `num_inputs`, default 4: highest channel index; there are num_inputs+1 channels, matching the neuron `spike_in` width.
- `value_size`, default 8: bits per channel intensity value.
- `window_length`, default 100: timesteps per encoding window; must be ≥1.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `values` input, [num_inputs:0][value_size-1:0]: intensity vector, sampled on a load handshake.
- `load_valid` input, 1 bit: `values` is valid.
- `load_ready` output, 1 bit: encoder is idle and accepts a load.
- `step` input, 1 bit: advance one timestep; ignored unless a window is running.
- `spike_out` output, [num_inputs:0]: registered spike vector, one-cycle pulses.
- `busy` output, 1 bit: a window is running.
- `window_done` output, 1 bit: one-cycle pulse after the last timestep of a window.

## Operation

- FSM states: IDLE and RUN.
- IDLE: `load_ready`=1, `busy`=0.
  - When `load_valid`&&`load_ready` at an edge, latch `values`, clear all accumulators and the timestep counter, and go to RUN.
- RUN: `load_ready`=0, `busy`=1. On each edge with `step`=1, for every channel i:
  - sum = acc[i] + value[i], computed at value_size+1 bits.
  - `spike_out[i]` <= sum[value_size] (the carry).
  - acc[i] <= sum[value_size-1:0]; the low bits wrap naturally.
  - The timestep counter increments. It is $clog2(window_length+1) bits wide.
- Edge with `step`=0 in RUN: `spike_out` <= 0; state, accumulators and counter hold.
- Last step: when the counter equals window_length-1 on a step edge, go to IDLE and set `window_done` <= 1 for one cycle. `spike_out` carries that final step's spikes in the same cycle.
- Spike count per channel over a window equals floor(window_length·v / 2^value_size).
  - v=0 never spikes.
  - v=2^value_size−1 misses one spike per 2^value_size steps.
- `load_valid` in RUN is ignored; the producer holds it until `load_ready`.
- Back-to-back windows: a load in the `window_done` cycle is accepted, because the state is already IDLE.
- `rst` asserted mid-window:
  - The block immediately returns to reset values.
  - No `window_done` is produced.
  - The partial window is discarded.

## Timing

- Reset values: state=IDLE, `load_ready`=1, `busy`=0, `spike_out`=0, `window_done`=0, accumulators=0, counter=0, latched values=0.
- Load edge → RUN; `busy`=1 and `load_ready`=0 starting the next cycle.
- `step` sampled at edge N → `spike_out` valid during cycle N+1 only (1-cycle latency).
- `window_done` is high in the cycle after the edge that sampled the final `step`. It is never asserted while in IDLE otherwise.
- `step` may be held high continuously; one timestep is consumed per cycle.
- `load_ready` and `busy` are decoded from registered state and are glitch-free.

## Configuration

- Macro `RATE_ENCODER_LFSR_EN`.
- Defined (stochastic, Poisson-like encoding):
  - Each channel owns a 16-bit maximal-length Galois LFSR (taps 0xB400).
  - Seed is 0xACE1 XOR (channel index+1); it is reloaded on reset and on each load.
  - Each step: `spike_out[i]` <= (lfsr[i][value_size-1:0] < value[i]), then the LFSR advances.
  - Accumulators are not built. v=0 still never spikes.
  - Requires value_size ≤16.
- Undefined: the deterministic accumulator encoder described above. No LFSR logic is synthesized.

## Structure

- Shared package `snn_pkg` holds:
  - the encoder state enum (IDLE, RUN);
  - LFSR taps and base seed constants.
- One sub-module, `spike_lfsr`: a parameterized 16-bit Galois LFSR with load/advance/seed inputs. It is instantiated once per channel, only under `RATE_ENCODER_LFSR_EN`.

## Test plan

- Reset check: assert `rst` mid-cycle → `load_ready`=1, `busy`=0, `spike_out`=0, `window_done`=0 asynchronously.
- Basic rate: value_size=8, window_length=8, channel values {64,128,0,255,32}, `step` held high → per-channel spike counts {2,4,0,7,1}. Channel 0 spikes on steps 4 and 8; `window_done` pulses once, in the cycle after step 8.
- Step gating: same load, `step` toggled 1-0-1-0 → `spike_out` is 0 in every cycle following `step`=0. The window completes after exactly 8 `step`=1 samples.
- Handshake: `load_valid` pulsed during RUN → ignored, `values` not re-latched. Load presented in the `window_done` cycle → accepted; `busy` is 1 in the next cycle.
- Reset mid-window: `rst` at step 3 of 8 → no `window_done`. A new load then restarts the counter and accumulators from 0, and the counts of the basic-rate test repeat exactly.
- `RATE_ENCODER_LFSR_EN` build, window_length=1000, values {0,255,128} → channel 0 produces 0 spikes; channel 1 produces ≥990; channel 2 produces 500±40.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN definitions: encoder FSM state codes, LFSR taps and seeds.
package snn_pkg;

    // Encoder FSM state codes
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // 16-bit maximal-length Galois LFSR taps and base seed
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Per-channel seed so channels decorrelate
    function automatic logic [15:0] lfsr_seed(input int unsigned ch);
        return LFSR_SEED ^ 16'(ch + 1);
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit Galois LFSR used by rate_encoder for stochastic spike generation.
// Only compiled when RATE_ENCODER_LFSR_EN is defined.
`ifdef RATE_ENCODER_LFSR_EN
module spike_lfsr #(
    parameter logic [15:0] taps = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Seed on reset/load, otherwise shift right with feedback on bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? taps : 16'h0000);
        end
    end

endmodule
`endif

// File: rtl/rate_encoder.sv
// Rate encoder: turns per-channel intensities into spike trains over a
// fixed window of timesteps. Define RATE_ENCODER_LFSR_EN for stochastic
// (LFSR comparison) encoding; default is the deterministic accumulator.
module rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned num_inputs    = 4,
    parameter int unsigned value_size    = 8,
    parameter int unsigned window_length = 100
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [num_inputs:0][value_size-1:0]  values,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic                                 step,
    output logic [num_inputs:0]                  spike_out,
    output logic                                 busy,
    output logic                                 window_done
);

    localparam int unsigned NCH   = num_inputs + 1;
    localparam int unsigned CNT_W = $clog2(window_length + 1);

    logic [0:0]                        state_q;
    logic [0:0]                        state_d;
    logic                              do_load;
    logic                              do_step;
    logic                              last_step;
    logic [CNT_W-1:0]                  count_q;
    logic [NCH-1:0][value_size-1:0]    vals_q;
    logic [NCH-1:0]                    spike_d;

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_step   = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    do_load = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    do_step = 1'b1;
                    if (count_q == CNT_W'(window_length - 1)) begin
                        last_step = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RATE_ENCODER_LFSR_EN
    logic [NCH-1:0][15:0] lfsr_q;

    // One LFSR per channel, reseeded on every load
    for (genvar g = 0; g < NCH; g++) begin : g_lfsr
        spike_lfsr #(
            .taps(LFSR_TAPS)
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .load    (do_load),
            .advance (do_step),
            .seed    (lfsr_seed(g)),
            .state   (lfsr_q[g])
        );
    end

    // Spike when the random sample falls below the intensity
    always_comb begin
        spike_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            spike_d[i] = (lfsr_q[i][value_size-1:0] < vals_q[i]);
        end
    end
`else
    logic [NCH-1:0][value_size-1:0] acc_q;
    logic [NCH-1:0][value_size:0]   sum;

    // Accumulate intensity; the carry out is the spike
    always_comb begin
        sum     = '0;
        spike_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sum[i]     = {1'b0, acc_q[i]} + {1'b0, vals_q[i]};
            spike_d[i] = sum[i][value_size];
        end
    end

    // Accumulators: cleared on load, wrap naturally on each step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (do_load) begin
            acc_q <= '0;
        end else if (do_step) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                acc_q[i] <= sum[i][value_size-1:0];
            end
        end
    end
`endif

    // Value latch, timestep counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vals_q      <= '0;
            count_q     <= '0;
            spike_out   <= '0;
            window_done <= 1'b0;
        end else begin
            spike_out   <= do_step ? spike_d : '0;
            window_done <= last_step;
            if (do_load) begin
                vals_q  <= values;
                count_q <= '0;
            end else if (do_step) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule
